// File: rtl/coreb_arbiter_rr.sv
// Core-B shared-bus arbiter: fixed-priority or round-robin grant, burst/lock hold, parking on DEF_MST.
// Optional lock timeout is built only when CORE_B_ARB_TIMEOUT_EN is defined.
module coreb_arbiter_rr #(
  parameter int NUM_MST = 16,
  parameter int IDX_W   = 4,
  parameter int RR_MODE = 1,
  parameter int DEF_MST = 0,
  parameter int TIMEOUT = 256
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_MST-1:0] MxREQ,
  input  logic               MmLK,
  input  logic               MmLST,
  input  logic               MsRDY,
  input  logic               MsERR,
  output logic [NUM_MST-1:0] AxGNT,
  output logic [NUM_MST-1:0] AmCMUX,
  output logic [IDX_W-1:0]   AmIDX,
  output logic               AbTO
);

  if (NUM_MST < 2 || NUM_MST > 32 || (2 ** IDX_W) < NUM_MST || DEF_MST < 0 ||
      DEF_MST >= NUM_MST || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_cfg_err
    $error("coreb_arbiter_rr: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  localparam logic [NUM_MST-1:0] DEF_OH  = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;
  localparam logic [IDX_W-1:0]   DEF_IDX = IDX_W'(DEF_MST);

  function automatic logic [NUM_MST-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_MST-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin searches upward from ptr+1 with wrap, so ptr itself is tried last.
  function automatic logic [IDX_W-1:0] f_pick(input logic [NUM_MST-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0]   win;
    logic [NUM_MST-1:0] sh;
    logic               found;
    int                 idx;
    win   = DEF_IDX;
    found = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (RR_MODE != 0) idx = (int'(ptr) + 1 + k) % NUM_MST;
      else              idx = k;
      sh = req >> idx;
      if (!found && sh[0]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  state_t             r_state;
  logic [NUM_MST-1:0] r_gnt;
  logic [IDX_W-1:0]   r_own;
  logic [NUM_MST-1:0] r_cmux;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_to;

  state_t             w_state_nxt;
  logic [NUM_MST-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]   w_own_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic               w_to_nxt;
  logic               w_rel;
  logic               w_req_own;
  logic               w_to_hit;
  logic [IDX_W-1:0]   w_win;

  assign w_req_own = |(MxREQ & r_gnt);
  assign w_win     = f_pick(MxREQ, r_ptr);

`ifdef CORE_B_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_cnt;
  logic        w_others;

  assign w_others = |(MxREQ & ~r_gnt);
  assign w_to_hit = (r_state == S_LOCK) && (r_cnt == TO_LAST);

  // Lock-hold counter: runs only while staying in LOCK with a competing request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= 16'd0;
    end else if (r_state != S_LOCK || w_state_nxt != S_LOCK) begin
      r_cnt <= 16'd0;
    end else if (w_others && r_cnt != TO_LAST) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state, release decision and new grant; everything holds without MsRDY.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_own_nxt   = r_own;
    w_ptr_nxt   = r_ptr;
    w_to_nxt    = 1'b0;
    w_rel       = 1'b0;
    if (MsRDY) begin
      case (r_state)
        S_IDLE: w_rel = 1'b1;
        S_OWN, S_LOCK: begin
          if (MsERR || w_to_hit) begin
            w_rel = 1'b1;
          end else if (MmLK) begin
            w_state_nxt = S_LOCK;
          end else if (MmLST || !w_req_own) begin
            w_rel = 1'b1;
          end else begin
            w_state_nxt = S_OWN;
          end
        end
        default: w_rel = 1'b1;
      endcase
      if (w_rel) begin
        if (MxREQ == {NUM_MST{1'b0}}) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = DEF_OH;
          w_own_nxt   = DEF_IDX;
        end else begin
          w_state_nxt = S_OWN;
          w_gnt_nxt   = f_onehot(w_win);
          w_own_nxt   = w_win;
          w_ptr_nxt   = w_win;
        end
      end else begin
        w_gnt_nxt = r_gnt;
      end
      w_to_nxt = w_to_hit;
    end else begin
      w_to_nxt = 1'b0;
    end
  end

  // Grant, address-phase select (one boundary behind the grant) and timeout pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gnt   <= DEF_OH;
      r_own   <= DEF_IDX;
      r_cmux  <= DEF_OH;
      r_idx   <= DEF_IDX;
      r_ptr   <= {IDX_W{1'b0}};
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_own   <= w_own_nxt;
      r_ptr   <= w_ptr_nxt;
      r_to    <= w_to_nxt;
      if (MsRDY) begin
        r_cmux <= r_gnt;
        r_idx  <= r_own;
      end else begin
        r_cmux <= r_cmux;
        r_idx  <= r_idx;
      end
    end
  end

  assign AxGNT  = r_gnt;
  assign AmCMUX = r_cmux;
  assign AmIDX  = r_idx;
  assign AbTO   = r_to;

endmodule

// File: doc/coreb_arbiter_rr.md
Name: coreb_arbiter_rr

Overview:
- Parametrised next-generation arbiter for the Core-B shared bus.
- Arbitrates NUM_MST masters with selectable fixed-priority or round-robin policy.
- Holds grant for bursts and locked sequences, parks on a default master, and drives the one-hot address-phase mux select for the command/write-data muxes.
- Sits between the masters' REQ lines and the M2S/S2M muxes; consumes MsRDY/MsERR from the read mux and MmLK/MmLST from the command mux.

Parameters:
- NUM_MST, 16, number of masters (2..32).
- IDX_W, 4, width of encoded owner index; must satisfy 2**IDX_W >= NUM_MST.
- RR_MODE, 1, arbitration policy: 1 = round-robin; 0 = fixed priority, lowest index highest.
- DEF_MST, 0, default/park master index when no request is pending.
- TIMEOUT, 256, lock-hold limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  bus clock.
- RST  in  1  synchronous, active-high reset.
- MxREQ  in  NUM_MST  per-master request, bit i = master i.
- MmLK  in  1  lock of the current address-phase transfer.
- MmLST  in  1  last beat of the current burst.
- MsRDY  in  1  transfer boundary; slave ready.
- MsERR  in  1  slave error, valid only when MsRDY=1.
- AxGNT  out  NUM_MST  one-hot grant to masters (registered).
- AmCMUX  out  NUM_MST  one-hot address-phase owner select (registered).
- AmIDX  out  IDX_W  binary index of the AmCMUX owner.
- AbTO  out  1  one-cycle lock-timeout pulse.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset values:
  - AxGNT = AmCMUX = one-hot DEF_MST.
  - AmIDX = DEF_MST.
  - AbTO = 0.
  - RR pointer = 0.
  - State = IDLE.
- States:
  - IDLE: parked on DEF_MST with no real owner.
  - OWN: granted master is transferring.
  - LOCK: a locked sequence is in progress.
- Boundary: any cycle with MsRDY=1. AxGNT, AmCMUX and the state change only at a boundary. With MsRDY=0 all state holds, including across MxREQ changes.
- AmCMUX/AmIDX: loaded from AxGNT at each boundary, so the address phase lags the grant by one boundary.
- Release condition at a boundary, when not locked: MmLST=1, or MxREQ[owner]=0, or MsERR=1.
- On release:
  - The new grant is computed from MxREQ in the same cycle and registered into AxGNT.
  - If MxREQ=0, grant parks on DEF_MST and the state goes to IDLE.
- Lock:
  - MmLK=1 at a boundary moves to LOCK and holds the grant regardless of MmLST or other requests.
  - LOCK is left at the first boundary with MmLK=0; release rules apply on that same boundary.
- Error: MsERR=1 at a boundary forces release even if MmLK=1 (LOCK -> re-arbitrate).
- Fixed priority: lowest set index of MxREQ wins.
- Round-robin:
  - Search starts at pointer+1 and wraps at NUM_MST-1 -> 0.
  - Pointer is loaded with the winner index on each grant change to a real request; it is not updated when parking.
- Single requester: a lone requester is granted at the first boundary after MxREQ rises. IDLE with MsRDY=1 gives a 1-cycle request-to-AxGNT latency.
- Re-grant: the same master may be re-granted back-to-back only if it is the sole requester (RR) or the highest priority (fixed).
- Simultaneous events:
  - MmLST=1 and MmLK=1 together: lock wins and the grant is held.
  - MsERR with MsRDY=0 is ignored.
- Reset mid-burst or mid-lock returns to the reset values on the next edge; no partial grant remains.

Optional Feature:
- Macro: CORE_B_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter increments each cycle in LOCK while any other MxREQ bit is set; it clears on leaving LOCK.
  - When the count reaches TIMEOUT-1, the next boundary forces release ignoring MmLK, pulses AbTO=1 for exactly that cycle, and clears the counter.
- When undefined: no counter is built, AbTO is tied 0, and LOCK is held indefinitely.

Test Plan:
- Reset then MxREQ=0 -> AxGNT=AmCMUX=16'h0001, AmIDX=0, AbTO=0, state IDLE.
- RR_MODE=1, MxREQ=16'h0013 held, MsRDY=1, MmLST=1 every cycle -> grant order 0,1,4,0,1,4; AmCMUX follows AxGNT one cycle later.
- RR_MODE=0, MxREQ=16'h0018 -> AxGNT=16'h0008 persists; drop bit 3 -> next boundary AxGNT=16'h0010.
- Master 2 owns, MmLK=1, MmLST=1 with MxREQ=16'h0005 -> AxGNT stays 16'h0004 until MmLK=0 at a boundary, then 16'h0001.
- Master 2 locked, MsRDY=1 with MsERR=1 -> same cycle release, next AxGNT=16'h0001; MsERR=1 with MsRDY=0 -> no change.
- CORE_B_ARB_TIMEOUT_EN, TIMEOUT=8, master 1 locked, MxREQ=16'h0003 -> after 8 cycles, next boundary AbTO=1 for one cycle and AxGNT=16'h0001; without the macro the grant is held for 100+ cycles and AbTO=0.
